// File: rtl/shiftreg_pkg.sv
// Shared types and limits for the shiftreg serial transmitter family.
package shiftreg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int CNT_W     = 15;
    localparam int MAX_WIDTH = 16384;

endpackage

// File: rtl/shiftreg_tx.sv
// Parallel-to-serial transmitter: one-word holding buffer feeding an MSB-first shifter.
// Optional even-parity bit after the LSB when SHIFTREG_TX_PARITY_EN is defined.
module shiftreg_tx
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] datain,
    input  logic             load,
    output logic             ready,
    output logic             databit,
    output logic             frame,
    output logic             busy
);

`ifdef SHIFTREG_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   shreg_reg, shreg_next;
    logic [WIDTH-1:0]   buf_reg, buf_next;
    logic               buf_valid_reg, buf_valid_next;
    logic               ready_reg;
`ifdef SHIFTREG_TX_PARITY_EN
    logic               parity_reg, parity_next;
`endif

    logic accept;
    logic last_bit;

    assign accept   = load && ready_reg;
    assign last_bit = (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shreg_reg     <= '0;
            buf_reg       <= '0;
            buf_valid_reg <= 1'b0;
            ready_reg     <= 1'b1;
`ifdef SHIFTREG_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shreg_reg     <= shreg_next;
            buf_reg       <= buf_next;
            buf_valid_reg <= buf_valid_next;
            // Registered copy keeps ready free of any path from load.
            ready_reg     <= !buf_valid_next;
`ifdef SHIFTREG_TX_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shreg_next     = shreg_reg;
        buf_next       = buf_reg;
        buf_valid_next = buf_valid_reg;
`ifdef SHIFTREG_TX_PARITY_EN
        parity_next    = parity_reg;
`endif

        // accept and transfer are exclusive: transfer needs buf_valid, accept needs ready.
        if (accept) begin
            buf_next       = datain;
            buf_valid_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (buf_valid_reg) begin
                    state_next     = SHIFT;
                    shreg_next     = buf_reg;
                    cnt_next       = '0;
                    buf_valid_next = 1'b0;
`ifdef SHIFTREG_TX_PARITY_EN
                    parity_next    = ^buf_reg;
`endif
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    cnt_next = '0;
                    if (buf_valid_reg) begin
                        shreg_next     = buf_reg;
                        buf_valid_next = 1'b0;
`ifdef SHIFTREG_TX_PARITY_EN
                        parity_next    = ^buf_reg;
`endif
                    end else begin
                        state_next = IDLE;
                        shreg_next = '0;
                    end
                end else begin
                    shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state_reg == SHIFT);
    assign frame = busy && (cnt_reg == '0);
    assign ready = ready_reg;

`ifdef SHIFTREG_TX_PARITY_EN
    assign databit = busy && ((cnt_reg == CNT_W'(WIDTH)) ? parity_reg : shreg_reg[WIDTH-1]);
`else
    assign databit = busy && shreg_reg[WIDTH-1];
`endif

endmodule

// File: tb/tb_shiftreg_tx.sv
// Directed bench for shiftreg_tx at WIDTH=8; parity frames when SHIFTREG_TX_PARITY_EN is defined.
module tb_shiftreg_tx;

    localparam int W = 8;
`ifdef SHIFTREG_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int NLB = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] datain = '0;
    logic         ready, databit, frame, busy;

    int vecs = 0;
    int errs = 0;

    bit exp_bits[$];
    bit exp_frm[$];

    shiftreg_tx #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .datain  (datain),
        .load    (load),
        .ready   (ready),
        .databit (databit),
        .frame   (frame),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_bits.push_back(w[W-1-i]);
            exp_frm.push_back(i == 0);
        end
`ifdef SHIFTREG_TX_PARITY_EN
        exp_bits.push_back(^w);
        exp_frm.push_back(1'b0);
`endif
    endfunction

    task automatic play(input string tag);
        while (exp_bits.size() > 0) begin
            @(negedge clk);
            chk1({tag, "_bit"}, databit, exp_bits.pop_front());
            chk1({tag, "_frame"}, frame, exp_frm.pop_front());
            chk1({tag, "_busy"}, busy, 1'b1);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_idle_busy"}, busy, 1'b0);
        chk1({tag, "_idle_bit"}, databit, 1'b0);
        chk1({tag, "_idle_frame"}, frame, 1'b0);
        chk1({tag, "_idle_ready"}, ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] sent[$];
        logic [W-1:0] rxw;
        logic [W-1:0] expw;
        int idx, rxcnt, nsent, gaps;
        bit started;

        // reset state while rst is held low
        #12;
        chk_idle("rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        // single word 0xA5 from idle
        load = 1'b1; datain = 8'hA5;
        @(negedge clk);
        load = 1'b0;
        chk1("a5_ready_low", ready, 1'b0);
        chk1("a5_not_busy_yet", busy, 1'b0);
        push_word(8'hA5);
        play("a5");
        @(negedge clk);
        chk_idle("a5");

        // back-to-back 0x81 then 0x7E, with an ignored 0xFF while ready=0
        load = 1'b1; datain = 8'h81;
        @(negedge clk);
        load = 1'b0;
        chk1("b2b_ready_after_accept", ready, 1'b0);
        push_word(8'h81);
        push_word(8'h7E);
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            chk1("b2b_bit", databit, exp_bits.pop_front());
            chk1("b2b_frame", frame, exp_frm.pop_front());
            chk1("b2b_busy", busy, 1'b1);
            chk1("b2b_ready", ready, !(i >= 1 && i < FL));
            if (i == 0) begin
                load = 1'b1; datain = 8'h7E;
            end else if (i == 1) begin
                load = 1'b1; datain = 8'hFF;
            end else begin
                load = 1'b0;
            end
        end
        @(negedge clk);
        chk_idle("b2b");

        // async reset at bit 3 of 0xA5 with 0xFF buffered; both must be discarded
        load = 1'b1; datain = 8'hA5;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("rstmid_bit", databit, (8'hA5 >> (7 - i)) & 1'b1);
            if (i == 0) begin
                load = 1'b1; datain = 8'hFF;
            end else begin
                load = 1'b0;
            end
        end
        #2 rst = 1'b0;
        #1;
        chk_idle("rstmid_async");
        @(negedge clk);
        chk_idle("rstmid_held");
        rst = 1'b1;
        load = 1'b1; datain = 8'h3C;
        @(negedge clk);
        load = 1'b0;
        chk1("3c_ready_low", ready, 1'b0);
        chk1("3c_not_busy_yet", busy, 1'b0);
        push_word(8'h3C);
        play("3c");
        @(negedge clk);
        chk_idle("3c");
        @(negedge clk);
        chk_idle("3c_no_resume");

        // parity-sensitive words: 0x07 (odd ones) and 0x03 (even ones)
        load = 1'b1; datain = 8'h07;
        @(negedge clk);
        load = 1'b0;
        push_word(8'h07);
        play("p07");
        @(negedge clk);
        chk_idle("p07");
        load = 1'b1; datain = 8'h03;
        @(negedge clk);
        load = 1'b0;
        push_word(8'h03);
        play("p03");
        @(negedge clk);
        chk_idle("p03");

        // loopback of random back-to-back words through a bench deserializer
        idx = 0; rxcnt = 0; nsent = 0; gaps = 0; started = 1'b0; rxw = '0;
        for (int cyc = 0; cyc < NLB * FL + 40 && rxcnt < NLB; cyc++) begin
            @(negedge clk);
            if (busy) begin
                started = 1'b1;
                if (frame) idx = 0;
                if (idx < W) begin
                    rxw = {rxw[W-2:0], databit};
                end else if (sent.size() > 0) begin
                    chk1("lb_parity", databit, ^sent[0]);
                end
                idx++;
                if (idx == FL) begin
                    expw = (sent.size() > 0) ? sent.pop_front() : ~rxw;
                    chkw("lb_word", 32'(rxw), 32'(expw));
                    rxcnt++;
                end
            end else if (started && rxcnt < NLB) begin
                gaps++;
            end
            if (ready && nsent < NLB) begin
                load = 1'b1;
                datain = W'($urandom);
                sent.push_back(datain);
                nsent++;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
        chkw("lb_count", 32'(rxcnt), 32'(NLB));
        chkw("lb_gaps", 32'(gaps), 32'd0);
        @(negedge clk);
        chk_idle("lb");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
